vga_mode_sched: RTL and testbench

Display-mode scheduler between the VGA timing generator and the pattern generators (gradient, colour-cycle, bars, …). It debounces two user keys, decides which of MODE_NUM generators owns the pixel path, and switches only on frame boundaries, inserting one blanked frame so a generator restarts cleanly. In auto mode it cycles through the generators every AUTO_FRAMES frames.

---
 rtl/vga_mode_sched_pkg.sv | 20 ++
 rtl/vga_mode_sched_if.sv | 35 +++
 rtl/vga_mode_sched_key_debounce.sv | 44 ++++
 rtl/vga_mode_sched.sv | 116 +++++++++++
 tb/tb_vga_mode_sched.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_mode_sched_pkg.sv
// Shared types and constants for the display-mode scheduler: FSM encoding,
// mode index width and RGB pixel format.
package vga_mode_sched_pkg;

  localparam int MODE_W = 2;
  localparam int RGB_W  = 24;
  localparam logic [RGB_W-1:0] RGB_BLACK = 24'h00_00_00;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Next generator index, wrapping after the last populated slot.
  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] mode,
                                                 input int num);
    return (int'(mode) >= num - 1) ? '0 : mode + MODE_W'(1);
  endfunction

endpackage

// File: rtl/vga_mode_sched_if.sv
// Pixel-path bundle between the timing generator, the pattern generators,
// the user keys and the mode scheduler.
interface vga_mode_sched_if
  import vga_mode_sched_pkg::*;
#(
  parameter int MODE_NUM = 4
) ();

  logic                       rgben;
  logic [10:0]                current_x;
  logic [10:0]                current_y;
  logic [10:0]                display_x;
  logic [10:0]                display_y;
  logic                       key_next;
  logic                       key_auto;
  logic [MODE_NUM*RGB_W-1:0]  mode_rgb_bus;
  logic [MODE_NUM-1:0]        mode_en;
  logic [MODE_W-1:0]          mode_sel;
  logic                       auto_on;
  logic                       frame_end;
  logic [RGB_W-1:0]           vga_buf_rgb;

  modport master (
    output rgben, current_x, current_y, display_x, display_y,
    output key_next, key_auto, mode_rgb_bus,
    input  mode_en, mode_sel, auto_on, frame_end, vga_buf_rgb
  );

  modport slave (
    input  rgben, current_x, current_y, display_x, display_y,
    input  key_next, key_auto, mode_rgb_bus,
    output mode_en, mode_sel, auto_on, frame_end, vga_buf_rgb
  );

endinterface

// File: rtl/vga_mode_sched_key_debounce.sv
// Active-low key debouncer: two-flop synchroniser, stable-low counter and a
// release lock so one held press yields exactly one single-cycle pulse.
module vga_key_debounce #(
  parameter logic [19:0] DEB_CNT = 20'd500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic [1:0]  sync;
  logic [19:0] cnt;
  logic        locked;

  // NOTE: asynchronous active-low reset lives in the sensitivity list; the
  // synchroniser also resets high so no phantom press follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      cnt    <= '0;
      locked <= 1'b0;
      press  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge value, whatever the statement order.
      sync  <= {sync[0], key};
      press <= 1'b0;
      if (sync[1]) begin
        cnt    <= '0;
        locked <= 1'b0;
      end else if (!locked) begin
        if (cnt == DEB_CNT - 20'd1) begin
          press  <= 1'b1;
          locked <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_mode_sched.sv
// Display-mode scheduler: picks which pattern generator drives the DAC,
// switching only on frame boundaries with one blanked frame in between.
module vga_mode_sched
  import vga_mode_sched_pkg::*;
#(
  parameter int          MODE_NUM    = 4,
  parameter logic [10:0] AUTO_FRAMES = 11'd300,
  parameter logic [19:0] DEB_CNT     = 20'd500_000
) (
  input  logic           VGA_CLK,
  input  logic           RST_N,
  vga_mode_sched_if.slave bus
);

  logic              press_next;
  logic              press_auto;
  logic [10:0]       last_x;
  logic [10:0]       last_y;
  logic              fe;
  logic              req_next;
  logic              req_auto;
  logic              auto_hit;
  logic [RGB_W-1:0]  slice;
  logic [MODE_NUM-1:0] mode_en;

  state_t            state;
  logic [MODE_W-1:0] mode;
  logic              auto_on;
  logic [10:0]       frame_cnt;
  logic              p_next;
  logic              p_auto;
  logic              frame_end;
  logic              en_d1;
  logic [RGB_W-1:0]  rgb;
  logic              live;

  vga_key_debounce #(.DEB_CNT(DEB_CNT)) u_key_next (
    .clk   (VGA_CLK),
    .rst_n (RST_N),
    .key   (bus.key_next),
    .press (press_next)
  );

  vga_key_debounce #(.DEB_CNT(DEB_CNT)) u_key_auto (
    .clk   (VGA_CLK),
    .rst_n (RST_N),
    .key   (bus.key_auto),
    .press (press_auto)
  );

  assign last_x = bus.display_x - 11'd1;
  assign last_y = bus.display_y - 11'd1;
  assign fe     = bus.rgben && (bus.current_x == last_x) && (bus.current_y == last_y);

  // A simultaneous auto press swallows the next press of the same cycle.
  assign req_auto = p_auto | press_auto;
  assign req_next = p_next | (press_next & ~press_auto);
  assign auto_hit = auto_on && (state == ST_RUN) && (frame_cnt == AUTO_FRAMES - 11'd1);

  assign slice = bus.mode_rgb_bus[RGB_W*int'(mode) +: RGB_W];

  // NOTE: default every always_comb output first so no latch is inferred.
  always_comb begin
    mode_en = '0;
    for (int k = 0; k < MODE_NUM; k++) begin
      mode_en[k] = live && bus.rgben && (int'(mode) == k);
    end
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_RUN;
      mode      <= '0;
      auto_on   <= 1'b0;
      frame_cnt <= '0;
      p_next    <= 1'b0;
      p_auto    <= 1'b0;
      frame_end <= 1'b0;
      en_d1     <= 1'b0;
      rgb       <= RGB_BLACK;
      live      <= 1'b0;
    end else begin
      live      <= 1'b1;
      en_d1     <= bus.rgben;
      frame_end <= fe;
      rgb       <= (en_d1 && state == ST_RUN) ? slice : RGB_BLACK;
      if (fe) begin
        p_next <= 1'b0;
        p_auto <= 1'b0;
        if (req_auto) begin
          auto_on   <= ~auto_on;
          frame_cnt <= '0;
          state     <= ST_RUN;
        end else if (req_next || auto_hit) begin
          mode      <= mode_inc(mode, MODE_NUM);
          frame_cnt <= '0;
          state     <= ST_BLANK;
        end else begin
          // Only shown frames count towards the auto period.
          if (auto_on && state == ST_RUN) frame_cnt <= frame_cnt + 11'd1;
          state <= ST_RUN;
        end
      end else begin
        p_next <= req_next;
        p_auto <= req_auto;
      end
    end
  end

  assign bus.mode_en     = mode_en;
  assign bus.mode_sel    = mode;
  assign bus.auto_on     = auto_on;
  assign bus.frame_end   = frame_end;
  assign bus.vga_buf_rgb = rgb;

endmodule

// File: tb/tb_vga_mode_sched.sv
// Frame-level directed bench for vga_mode_sched on an 8x4 active raster
// (10x5 total); expected pixels are queued by the driver and popped by a monitor.
`timescale 1ns/1ps
module tb_vga_mode_sched;
  import vga_mode_sched_pkg::*;

  localparam int H_TOT = 10;
  localparam int V_TOT = 5;
  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam logic [23:0] K  = 24'h000000;
  localparam logic [23:0] C0 = 24'h111111;
  localparam logic [23:0] C1 = 24'h222222;
  localparam logic [23:0] C2 = 24'h333333;
  localparam logic [23:0] C3 = 24'h444444;

  typedef struct {
    int          nx_start, nx_len, nx_cnt;
    int          au_start, au_len;
    int          rs_start, rs_len;
    logic [23:0] color, last_color;
    int          mode_after;
    logic        auto_after;
  } frame_t;

  logic VGA_CLK = 1'b0;
  logic RST_N   = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  vga_mode_sched_if #(.MODE_NUM(4)) bus ();
  assign bus.mode_rgb_bus = {C3, C2, C1, C0};

  vga_mode_sched #(
    .MODE_NUM    (4),
    .AUTO_FRAMES (11'd2),
    .DEB_CNT     (20'd4)
  ) dut (
    .VGA_CLK (VGA_CLK),
    .RST_N   (RST_N),
    .bus     (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  frame_t      plan[$];
  logic        pushed = 1'b0;
  logic        last_px = 1'b0;
  logic [1:0]  push_pipe = 2'b00;
  logic        lp_d1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input int c, input int s, input int len, input int cnt);
    for (int i = 0; i < cnt; i++)
      if (c >= s + i*8 && c < s + i*8 + len) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add(input int nx_s, input int nx_l, input int nx_c,
                     input int au_s, input int au_l, input int rs_s, input int rs_l,
                     input logic [23:0] color, input logic [23:0] last,
                     input int mode_after, input logic auto_after);
    frame_t f;
    f.nx_start = nx_s; f.nx_len = nx_l; f.nx_cnt = nx_c;
    f.au_start = au_s; f.au_len = au_l;
    f.rs_start = rs_s; f.rs_len = rs_l;
    f.color = color; f.last_color = last;
    f.mode_after = mode_after; f.auto_after = auto_after;
    plan.push_back(f);
  endtask

  task automatic plain(input logic [23:0] color, input logic [23:0] last,
                       input int mode_after, input logic auto_after);
    add(0, 0, 0, 0, 0, 0, 0, color, last, mode_after, auto_after);
  endtask

  // Monitor: output for a pixel driven after edge n is visible after edge n+2.
  always @(negedge VGA_CLK) begin
    if (push_pipe[1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got pixel %h with no expected entry", bus.vga_buf_rgb);
      end else begin
        check("vga_buf_rgb", bus.vga_buf_rgb, exp_q.pop_front());
      end
    end else if (bus.vga_buf_rgb !== K) begin
      check("vga_buf_rgb_idle", bus.vga_buf_rgb, K);
    end
    if (bus.frame_end || lp_d1) check("frame_end", bus.frame_end, lp_d1);
    push_pipe = {push_pipe[0], pushed};
    lp_d1     = last_px;
  end

  task automatic run_frame(input frame_t f, input int prev_mode);
    int x, y;
    bit en;
    for (int c = 0; c < H_TOT*V_TOT; c++) begin
      @(posedge VGA_CLK);
      #1;
      x  = c % H_TOT;
      y  = c / H_TOT;
      en = (x < H_ACT) && (y < V_ACT);
      bus.current_x = 11'(x);
      bus.current_y = 11'(y);
      bus.rgben     = en;
      bus.key_next  = !in_win(c, f.nx_start, f.nx_len, f.nx_cnt);
      bus.key_auto  = !in_win(c, f.au_start, f.au_len, 1);
      RST_N         = !in_win(c, f.rs_start, f.rs_len, 1);
      pushed        = en;
      last_px       = en && (x == H_ACT-1) && (y == V_ACT-1);
      if (en) begin
        if (last_px || (f.rs_len > 0 && c >= f.rs_start + f.rs_len))
          exp_q.push_back(f.last_color);
        else
          exp_q.push_back(f.color);
      end
      @(negedge VGA_CLK);
      if (c == 0) check("mode_en_active", bus.mode_en, 4'b0001 << prev_mode);
      if (c == 9) check("mode_en_idle", bus.mode_en, 4'b0000);
      if (f.rs_len > 0 && c == f.rs_start) begin
        check("rst_mode_sel", bus.mode_sel, 0);
        check("rst_auto_on", bus.auto_on, 0);
        check("rst_mode_en", bus.mode_en, 0);
        check("rst_rgb", bus.vga_buf_rgb, K);
      end
      if (c == 45) begin
        check("mode_sel", bus.mode_sel, f.mode_after);
        check("auto_on", bus.auto_on, f.auto_after);
      end
    end
  endtask

  initial begin
    int prev_mode;
    bus.rgben = 1'b0;
    bus.current_x = '0;
    bus.current_y = '0;
    bus.display_x = 11'(H_ACT);
    bus.display_y = 11'(V_ACT);
    bus.key_next = 1'b1;
    bus.key_auto = 1'b1;
    repeat (2) @(posedge VGA_CLK);
    #1 bus.rgben = 1'b1;
    @(negedge VGA_CLK);
    check("reset_mode_sel", bus.mode_sel, 0);
    check("reset_auto_on", bus.auto_on, 0);
    check("reset_frame_end", bus.frame_end, 0);
    check("reset_rgb", bus.vga_buf_rgb, K);
    check("reset_mode_en", bus.mode_en, 0);
    @(posedge VGA_CLK);
    #1;
    bus.rgben = 1'b0;
    RST_N = 1'b1;
    repeat (3) @(posedge VGA_CLK);

    plain(C0, C0, 0, 0);                        // F0 idle in mode 0
    plain(C0, C0, 0, 0);
    add(2, 3, 1, 0, 0, 0, 0, C0, C0, 0, 0);     // 3-cycle glitch: no change
    add(12, 6, 1, 0, 0, 0, 0, C0, K, 1, 0);     // NEXT mid-frame
    plain(K, C1, 1, 0);                         // blank frame
    plain(C1, C1, 1, 0);
    add(0, 6, 3, 0, 0, 0, 0, C1, K, 2, 0);      // three presses, one advance
    plain(K, C2, 2, 0);
    add(0, 6, 1, 0, 0, 0, 0, C2, K, 3, 0);
    plain(K, C3, 3, 0);
    add(0, 6, 1, 0, 0, 0, 0, C3, K, 0, 0);      // wrap 3 -> 0
    plain(K, C0, 0, 0);
    add(0, 0, 0, 0, 6, 0, 0, C0, C0, 0, 1);     // auto on
    plain(C0, C0, 0, 1);
    plain(C0, K, 1, 1);
    plain(K, C1, 1, 1);
    plain(C1, C1, 1, 1);
    plain(C1, K, 2, 1);
    plain(K, C2, 2, 1);
    plain(C2, C2, 2, 1);
    plain(C2, K, 3, 1);
    plain(K, C3, 3, 1);
    plain(C3, C3, 3, 1);
    plain(C3, K, 0, 1);
    plain(K, C0, 0, 1);
    plain(C0, C0, 0, 1);
    add(0, 0, 0, 0, 6, 0, 0, C0, C0, 0, 0);     // auto off beats due advance
    plain(C0, C0, 0, 0);
    add(0, 6, 1, 0, 6, 0, 0, C0, C0, 0, 1);     // simultaneous: auto only
    plain(C0, C0, 0, 1);
    plain(C0, K, 1, 1);
    plain(K, C1, 1, 1);
    plain(C1, C1, 1, 1);
    plain(C1, K, 2, 1);
    add(0, 0, 0, 0, 0, 15, 5, K, C0, 0, 0);     // reset during blank in mode 2
    plain(C0, C0, 0, 0);

    prev_mode = 0;
    foreach (plan[i]) begin
      run_frame(plan[i], prev_mode);
      prev_mode = plan[i].mode_after;
    end

    repeat (4) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
